// File: rtl/simd_wr_dispatch.sv
// rtl/simd_wr_dispatch.sv - per-namespace write dispatch FIFO with independent partial retirement
// Optional feature: define SIMD_WR_DROP_CNT_EN to add the saturating drop_cnt output.
module simd_wr_dispatch #(
  parameter int BASE_STRIDE_WIDTH = 32,
  parameter int DATA_WIDTH        = 256,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [5:0]                   buf_wr_req_in,
  input  logic [BASE_STRIDE_WIDTH-1:0] buf_wr_addr_in,
  input  logic [DATA_WIDTH-1:0]        wr_data_in,
  input  logic [5:0]                   ns_wr_ready,
  output logic [5:0]                   ns_wr_en,
  output logic [BASE_STRIDE_WIDTH-1:0] ns_wr_addr,
  output logic [DATA_WIDTH-1:0]        ns_wr_data,
  output logic                         stall_out,
  output logic                         busy,
  output logic                         overflow_err
`ifdef SIMD_WR_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_C   = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] STALL_LVL = OW'(FIFO_DEPTH - 1);

  logic [5:0]                   req_q  [FIFO_DEPTH];
  logic [5:0]                   req_d  [FIFO_DEPTH];
  logic [BASE_STRIDE_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [BASE_STRIDE_WIDTH-1:0] addr_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]        data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]        data_d [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]                occ_q, occ_d;
  logic                         ovf_q, ovf_d;

  logic       nonempty, retire, push_req, push_ok, drop;
  logic [5:0] head_req, head_rem;

  always_comb begin
    nonempty = (occ_q != '0);
    head_req = req_q[rd_ptr_q];
    // Bits still owed after this cycle's strobes; the head retires once none remain.
    head_rem = head_req & ~ns_wr_ready;
    retire   = nonempty && (head_rem == 6'b0);
    push_req = (buf_wr_req_in != 6'b0);
    push_ok  = push_req && ((occ_q < DEPTH_C) || retire);
    drop     = push_req && !push_ok;
  end

  always_comb begin
    ns_wr_en     = (nonempty && reset) ? (head_req & ns_wr_ready) : 6'b0;
    ns_wr_addr   = nonempty ? addr_q[rd_ptr_q] : '0;
    ns_wr_data   = nonempty ? data_q[rd_ptr_q] : '0;
    stall_out    = (occ_q >= STALL_LVL);
    busy         = nonempty;
    overflow_err = ovf_q;
  end

  always_comb begin
    req_d    = req_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | drop;
    if (nonempty) begin
      req_d[rd_ptr_q] = head_rem;
    end
    if (retire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // When full, the push lands in the slot the head is vacating, so it must win.
    if (push_ok) begin
      req_d[wr_ptr_q]  = buf_wr_req_in;
      addr_d[wr_ptr_q] = buf_wr_addr_in;
      data_d[wr_ptr_q] = wr_data_in;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    unique case ({push_ok, retire})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        req_q[i] <= 6'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      req_q    <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

`ifdef SIMD_WR_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
